// File: rtl/ysyx_23060124_axil_sram_pkg.sv
// rtl/ysyx_23060124_axil_sram_pkg.sv - shared constants, FSM encodings and address decode helpers
package ysyx_23060124_axil_sram_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      W_IDLE,
      W_RESP
   } w_state_e;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_RESP
   } r_state_e;

   // 33-bit compare so a window ending at the top of the address space still decodes
   function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base,
                                     input logic [32:0] span);
      logic [32:0] off;
      off = {1'b0, addr} - {1'b0, base};
      return (addr >= base) && (off < span);
   endfunction

   function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
      return (addr - base) >> 2;
   endfunction

endpackage

// File: rtl/ysyx_23060124_sram_bytewr.sv
// rtl/ysyx_23060124_sram_bytewr.sv - word array with one byte-enabled write port and one registered read port
module ysyx_23060124_sram_bytewr #(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_widx,
   input  logic [31:0]      i_wdata,
   input  logic [3:0]       i_wstrb,
   input  logic             i_re,
   input  logic [IDX_W-1:0] i_ridx,
   output logic [31:0]      o_rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int b = 0; b < 4; b++) begin
            if (i_wstrb[b]) r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
   end

   // A read and a write on the same edge see the pre-write contents
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)  o_rdata <= '0;
      else if (i_re) o_rdata <= r_mem[i_ridx];
   end

endmodule

// File: rtl/ysyx_23060124_axil_sram.sv
// rtl/ysyx_23060124_axil_sram.sv - AXI4-Lite responder over a byte-strobed SRAM
// Independent write and read FSMs; reads have a programmable wait before RVALID.
module ysyx_23060124_axil_sram
   import ysyx_23060124_axil_sram_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          RD_LATENCY  = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] S_AXI_AWADDR,
   input  logic        S_AXI_AWVALID,
   output logic        S_AXI_AWREADY,
   input  logic [31:0] S_AXI_WDATA,
   input  logic [3:0]  S_AXI_WSTRB,
   input  logic        S_AXI_WVALID,
   output logic        S_AXI_WREADY,
   output logic [1:0]  S_AXI_BRESP,
   output logic        S_AXI_BVALID,
   input  logic        S_AXI_BREADY,
   input  logic [31:0] S_AXI_ARADDR,
   input  logic        S_AXI_ARVALID,
   output logic        S_AXI_ARREADY,
   output logic [31:0] S_AXI_RDATA,
   output logic [1:0]  S_AXI_RRESP,
   output logic        S_AXI_RVALID,
   input  logic        S_AXI_RREADY
);

   localparam int          IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;
   localparam logic [3:0]  LAT   = 4'(RD_LATENCY);

   w_state_e    r_wst;
   logic        r_aw_got;
   logic        r_w_got;
   logic [31:0] r_awaddr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic        r_awready;
   logic        r_wready;
   logic        r_bvalid;
   logic [1:0]  r_bresp;

   r_state_e    r_rst;
   logic [31:0] r_araddr;
   logic [3:0]  r_cnt;
   logic        r_arready;
   logic        r_rvalid;
   logic [1:0]  r_rresp;

   logic             w_aw_hs;
   logic             w_w_hs;
   logic [31:0]      w_aw_addr;
   logic [31:0]      w_w_data;
   logic [3:0]       w_w_strb;
   logic             w_whit;
   logic             w_commit;
   logic [IDX_W-1:0] w_widx;
   logic             w_ar_hs;
   logic [31:0]      w_r_addr;
   logic             w_rhit;
   logic             w_rsample;
   logic [IDX_W-1:0] w_ridx;
   logic [31:0]      w_rdata;

   // Whichever half arrives on the completing edge is taken straight from the bus
   assign w_aw_hs   = S_AXI_AWVALID && r_awready;
   assign w_w_hs    = S_AXI_WVALID && r_wready;
   assign w_aw_addr = r_aw_got ? r_awaddr : S_AXI_AWADDR;
   assign w_w_data  = r_w_got ? r_wdata : S_AXI_WDATA;
   assign w_w_strb  = r_w_got ? r_wstrb : S_AXI_WSTRB;
   assign w_whit    = addr_hit(w_aw_addr, BASE_ADDR, SPAN);
   assign w_widx    = IDX_W'(word_index(w_aw_addr, BASE_ADDR));
   assign w_commit  = (r_wst == W_IDLE) && (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs);

   assign w_ar_hs   = S_AXI_ARVALID && r_arready;
   assign w_r_addr  = (r_rst == R_IDLE) ? S_AXI_ARADDR : r_araddr;
   assign w_rhit    = addr_hit(w_r_addr, BASE_ADDR, SPAN);
   assign w_ridx    = IDX_W'(word_index(w_r_addr, BASE_ADDR));
   assign w_rsample = ((r_rst == R_IDLE) && w_ar_hs && (LAT == 4'd0)) ||
                      ((r_rst == R_WAIT) && (r_cnt == 4'd1));

   ysyx_23060124_sram_bytewr #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_mem (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_we    (w_commit && w_whit),
      .i_widx  (w_widx),
      .i_wdata (w_w_data),
      .i_wstrb (w_w_strb),
      .i_re    (w_rsample && w_rhit),
      .i_ridx  (w_ridx),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wst     <= W_IDLE;
         r_aw_got  <= 1'b0;
         r_w_got   <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
      end else begin
         case (r_wst)
            W_IDLE: begin
               if (w_aw_hs) begin
                  r_aw_got <= 1'b1;
                  r_awaddr <= S_AXI_AWADDR;
               end
               if (w_w_hs) begin
                  r_w_got <= 1'b1;
                  r_wdata <= S_AXI_WDATA;
                  r_wstrb <= S_AXI_WSTRB;
               end
               if (w_commit) begin
                  r_wst     <= W_RESP;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b0;
                  r_bvalid  <= 1'b1;
                  r_bresp   <= w_whit ? RESP_OKAY : RESP_SLVERR;
               end else begin
                  r_awready <= !(r_aw_got || w_aw_hs);
                  r_wready  <= !(r_w_got || w_w_hs);
               end
            end
            W_RESP: begin
               if (S_AXI_BREADY) begin
                  r_wst     <= W_IDLE;
                  r_aw_got  <= 1'b0;
                  r_w_got   <= 1'b0;
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
               end
            end
            default: r_wst <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rst     <= R_IDLE;
         r_araddr  <= '0;
         r_cnt     <= '0;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rresp   <= RESP_OKAY;
      end else begin
         case (r_rst)
            R_IDLE: begin
               if (w_ar_hs) begin
                  r_araddr  <= S_AXI_ARADDR;
                  r_cnt     <= LAT;
                  r_arready <= 1'b0;
                  if (LAT == 4'd0) begin
                     r_rst    <= R_RESP;
                     r_rvalid <= 1'b1;
                     r_rresp  <= w_rhit ? RESP_OKAY : RESP_SLVERR;
                  end else begin
                     r_rst <= R_WAIT;
                  end
               end else begin
                  r_arready <= 1'b1;
               end
            end
            R_WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_rst    <= R_RESP;
                  r_rvalid <= 1'b1;
                  r_rresp  <= w_rhit ? RESP_OKAY : RESP_SLVERR;
               end
            end
            R_RESP: begin
               if (S_AXI_RREADY) begin
                  r_rst     <= R_IDLE;
                  r_rvalid  <= 1'b0;
                  r_arready <= 1'b1;
               end
            end
            default: r_rst <= R_IDLE;
         endcase
      end
   end

   assign S_AXI_AWREADY = r_awready;
   assign S_AXI_WREADY  = r_wready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_ARREADY = r_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RRESP   = r_rresp;
   // The read register holds stale data after a miss, so an error response masks it
   assign S_AXI_RDATA   = (r_rresp == RESP_SLVERR) ? 32'h0 : w_rdata;

endmodule
